ram16_word: RTL and testbench

16-word × 8-bit register-file RAM with one synchronous write port and one combinational read port. Its read data drives a tri-state output so it can sit directly on the CPU's shared 8-bit data bus. The controller owns all control signals: RE places the addressed word on the bus, and WE captures WD at the next clock edge. Contents clear to zero on reset.

---
 rtl/cpu_pkg.sv | 11 +
 rtl/bus_tribuf.sv | 12 +
 rtl/ram16_word.sv | 50 +++++
 tb/tb_ram16_word.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath types and sizes used by the register-file RAM, controller and ALU.
package cpu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/bus_tribuf.sv
// Tri-state driver onto a shared bus; releases the bus (all Z) when not enabled.
module bus_tribuf #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output tri   [DATA_W-1:0] y
);

  assign y = en ? d : {DATA_W{1'bz}};

endmodule

// File: rtl/ram16_word.sv
// 16 x 8 register-file RAM: synchronous write, combinational read driven onto the shared data bus.
module ram16_word
  import cpu_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              WE,
  input  logic              RE,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] WD,
  output tri   [DATA_W-1:0] Q
);

  word_t mem_q [DEPTH];
  word_t mem_d [DEPTH];
  word_t rd_data_c;
  logic  rd_en_c;

  // Next-state of the array; an unknown WE falls to the else path and writes nothing.
  always_comb begin
    mem_d = mem_q;
    if (WE) begin
      mem_d[WA] = WD;
    end
  end

  // Plain flops so every word can be cleared asynchronously.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data_c = mem_q[RA];
  assign rd_en_c   = RE & RESET_N;

  bus_tribuf #(
    .DATA_W(DATA_W)
  ) u_q_drv (
    .en(rd_en_c),
    .d (rd_data_c),
    .y (Q)
  );

endmodule

// File: tb/tb_ram16_word.sv
// Directed self-checking bench for ram16_word; a pull-up on the bus makes a released bus read 8'hFF.
module tb_ram16_word;

  localparam logic [7:0] BUS_IDLE = 8'hFF;

  logic       clk;
  logic       rst_n;
  logic       we;
  logic       re;
  logic [3:0] ra;
  logic [3:0] wa;
  logic [7:0] wd;
  logic       tb_en;
  logic [7:0] tb_drv;
  tri   [7:0] bus;

  int n_chk;
  int n_pass;

  pullup (bus);
  assign bus = tb_en ? tb_drv : 8'hzz;

  ram16_word dut (
    .CLK    (clk),
    .RESET_N(rst_n),
    .WE     (we),
    .RE     (re),
    .RA     (ra),
    .WA     (wa),
    .WD     (wd),
    .Q      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    we = 1'b1;
    wa = a;
    wd = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
    ra = a;
    #1;
    chk(tag, bus, exp);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    we     = 1'b0;
    re     = 1'b1;
    ra     = 4'd0;
    wa     = 4'd0;
    wd     = 8'h00;
    tb_en  = 1'b0;
    tb_drv = 8'h00;

    // Reset: bus released while reset is low even with RE=1
    @(posedge clk);
    #1;
    chk("rst_q_z", bus, BUS_IDLE);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) rd_chk("rst_word", 4'(i), 8'h00);
    re = 1'b0;
    #1;
    chk("re0_z", bus, BUS_IDLE);
    re = 1'b1;

    // Unknown WE must not write
    we = 1'bx;
    wa = 4'd4;
    wd = 8'h77;
    @(posedge clk);
    #1;
    we = 1'b0;
    rd_chk("we_x_nowrite", 4'd4, 8'h00);

    // Write/readback of every word
    for (int i = 0; i < 16; i++) wr(4'(i), 8'hA0 + 8'(i));
    for (int i = 0; i < 16; i++) rd_chk("wr_rd", 4'(i), 8'hA0 + 8'(i));
    wr(4'd9, 8'h5C);
    rd_chk("wr9", 4'd9, 8'h5C);
    rd_chk("nbr8", 4'd8, 8'hA8);
    rd_chk("nbr10", 4'd10, 8'hAA);

    // WE=0 hold for three edges
    wa = 4'd5;
    wd = 8'hFF;
    we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rd_chk("we0_hold", 4'd5, 8'hA5);

    // Read-during-write to the same address: old data before the edge, new after
    wr(4'd3, 8'h11);
    ra = 4'd3;
    wa = 4'd3;
    wd = 8'h22;
    we = 1'b1;
    #1;
    chk("rdw_before", bus, 8'h11);
    @(posedge clk);
    #1;
    we = 1'b0;
    chk("rdw_after", bus, 8'h22);

    // Async reset between edges; a write attempted during reset is dropped
    ra = 4'd9;
    #1;
    chk("pre_rst", bus, 8'h5C);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_z", bus, BUS_IDLE);
    we = 1'b1;
    wa = 4'd7;
    wd = 8'hEE;
    @(posedge clk);
    #1;
    we = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) rd_chk("post_rst", 4'(i), 8'h00);
    @(posedge clk);
    #1;
    rd_chk("rst_wr_dropped", 4'd7, 8'h00);
    wr(4'd7, 8'h3C);
    rd_chk("post_rst_wr", 4'd7, 8'h3C);

    // Bus sharing: bench drives only while the RAM has released the bus
    re = 1'b1;
    rd_chk("share_ram", 4'd7, 8'h3C);
    re = 1'b0;
    tb_drv = 8'h5A;
    tb_en  = 1'b1;
    #1;
    chk("share_tb", bus, 8'h5A);
    tb_en = 1'b0;
    #1;
    chk("share_idle", bus, BUS_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
